// File: rtl/test_pattern_scheduler_pkg.sv
// Shared constants for the test-pattern path: the one-hot pattern encodings,
// their cycling order, and the width of the auto-mode dwell counter.
package test_pattern_scheduler_pkg;

    localparam int PATTERN_W = 4;
    localparam int DWELL_W   = 8;

    // One-hot select values understood by the image and test-screen generators.
    typedef enum logic [PATTERN_W-1:0] {
        RECTANGLE  = 4'b0001,
        V_BARS     = 4'b0010,
        H_BARS     = 4'b0100,
        GRAY_SCALE = 4'b1000
    } pattern_e;

    // Successor in the display order; anything that is not a legal one-hot
    // code recovers to RECTANGLE so a corrupted select self-heals in one step.
    function automatic logic [PATTERN_W-1:0] next_pattern(input logic [PATTERN_W-1:0] cur);
        logic [PATTERN_W-1:0] nxt;
        case (cur)
            RECTANGLE:  nxt = V_BARS;
            V_BARS:     nxt = H_BARS;
            H_BARS:     nxt = GRAY_SCALE;
            GRAY_SCALE: nxt = RECTANGLE;
            default:    nxt = RECTANGLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/test_pattern_scheduler_debouncer.sv
// Push-button conditioner: two-flop synchronizer followed by a counting
// debouncer. Level is the accepted (debounced) button level, idle high.
// Press is a single-cycle pulse on each accepted 1->0 transition.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic Clock,
    input  logic Reset,
    input  logic In,
    output logic Level,
    output logic Press
);
    import test_pattern_scheduler_pkg::*;

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

    logic sync1_reg;
    logic sync2_reg;
    logic level_reg;
    logic level_next;
    logic press_reg;
    logic press_next;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    // Bring the raw button into the Clock domain; idle level is released (1).
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
        end else begin
            sync1_reg <= In;
            sync2_reg <= sync1_reg;
        end
    end

    // Count consecutive cycles the synchronized input disagrees with the
    // accepted level; any agreeing cycle restarts the count.
    always_comb begin
        level_next = level_reg;
        count_next = '0;
        press_next = 1'b0;
        if (sync2_reg != level_reg) begin
            if (count_reg == LAST_COUNT) begin
                level_next = sync2_reg;
                press_next = level_reg;
            end else begin
                count_next = count_reg + 1'b1;
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            level_reg <= 1'b1;
            count_reg <= '0;
            press_reg <= 1'b0;
        end else begin
            level_reg <= level_next;
            count_reg <= count_next;
            press_reg <= press_next;
        end
    end

    assign Level = level_reg;
    assign Press = press_reg;

endmodule

// File: rtl/test_pattern_scheduler.sv
// Test-pattern scheduler: picks which pattern the image generator shows.
// Patterns only ever change on a frame boundary; the user can step through
// them with the Next button or toggle automatic cycling with the Mode button.
module test_pattern_scheduler
    import test_pattern_scheduler_pkg::*;
#(
    parameter int           DWELL_FRAMES    = 150,
    parameter int           DEBOUNCE_CYCLES = 65536,
    parameter logic [3:0]   INITIAL_STATE   = 4'b0001
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       VS,
    input  logic       BtnNext,
    input  logic       BtnMode,
    output logic [3:0] ImageState,
    output logic       AutoMode,
    output logic       FrameTick
);

    localparam logic [DWELL_W-1:0] DWELL_RELOAD = DWELL_W'(DWELL_FRAMES);

    logic next_level;
    logic next_press;
    logic mode_level;
    logic mode_press;
    logic unused_levels;

    logic                 vs_prev_reg;
    logic                 vs_prev_next;
    logic                 frame_tick_reg;
    logic                 frame_tick_next;
    logic [PATTERN_W-1:0] image_state_reg;
    logic [PATTERN_W-1:0] image_state_next;
    logic                 auto_mode_reg;
    logic                 auto_mode_next;
    logic [DWELL_W-1:0]   dwell_reg;
    logic [DWELL_W-1:0]   dwell_next;
    logic                 pending_reg;
    logic                 pending_next;
    logic                 dwell_expired;
    logic                 advance;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_next_btn (
        .Clock(Clock),
        .Reset(Reset),
        .In   (BtnNext),
        .Level(next_level),
        .Press(next_press)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_mode_btn (
        .Clock(Clock),
        .Reset(Reset),
        .In   (BtnMode),
        .Level(mode_level),
        .Press(mode_press)
    );

    // Only the press pulses drive scheduling; the debounced levels are spare.
    assign unused_levels = next_level ^ mode_level;

    // Frame boundary detection and advance decision for this cycle.
    always_comb begin
        frame_tick_next = VS & ~vs_prev_reg;
        vs_prev_next    = VS;
        dwell_expired   = auto_mode_reg && (dwell_reg <= 8'd1);
        // A pending request and dwell expiry on the same tick merge into one step.
        advance         = frame_tick_reg && (pending_reg || dwell_expired);
    end

    // Next-state logic for pattern select, mode, dwell counter and pending flag.
    always_comb begin
        image_state_next = image_state_reg;
        auto_mode_next   = auto_mode_reg;
        dwell_next       = dwell_reg;
        pending_next     = pending_reg;

        if (advance) begin
            image_state_next = next_pattern(image_state_reg);
            pending_next     = 1'b0;
            if (auto_mode_reg) begin
                dwell_next = DWELL_RELOAD;
            end
        end else if (frame_tick_reg && auto_mode_reg) begin
            dwell_next = dwell_reg - 1'b1;
        end

        // A press landing on the tick itself is kept for the following frame,
        // so it overrides the clear above.
        if (next_press) begin
            pending_next = 1'b1;
        end

        // Entering auto restarts a full dwell period.
        if (mode_press) begin
            auto_mode_next = ~auto_mode_reg;
            if (!auto_mode_reg) begin
                dwell_next = DWELL_RELOAD;
            end
        end
    end

    // Scheduler state registers.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            vs_prev_reg     <= 1'b0;
            frame_tick_reg  <= 1'b0;
            image_state_reg <= INITIAL_STATE;
            auto_mode_reg   <= 1'b1;
            dwell_reg       <= DWELL_RELOAD;
            pending_reg     <= 1'b0;
        end else begin
            vs_prev_reg     <= vs_prev_next;
            frame_tick_reg  <= frame_tick_next;
            image_state_reg <= image_state_next;
            auto_mode_reg   <= auto_mode_next;
            dwell_reg       <= dwell_next;
            pending_reg     <= pending_next;
        end
    end

    assign ImageState = image_state_reg;
    assign AutoMode   = auto_mode_reg;
    assign FrameTick  = frame_tick_reg;

endmodule

// File: tb/tb_test_pattern_scheduler.sv
// Self-checking bench for test_pattern_scheduler (DWELL_FRAMES=3,
// DEBOUNCE_CYCLES=4). Every FrameTick consumes one expected
// {ImageState, AutoMode} record from a queue filled as VS pulses are driven.
module tb_test_pattern_scheduler;

    logic       Clock;
    logic       Reset;
    logic       VS;
    logic       BtnNext;
    logic       BtnMode;
    logic [3:0] ImageState;
    logic       AutoMode;
    logic       FrameTick;

    typedef struct packed {
        logic [3:0] state;
        logic       auto_mode;
    } exp_t;

    typedef struct {
        int         vs_high;
        logic [3:0] exp_state;
        logic       exp_auto;
    } vec_t;

    exp_t       exp_q[$];
    int         checks;
    int         failures;
    logic [3:0] prev_state;
    bit         cmp_due;

    test_pattern_scheduler #(
        .DWELL_FRAMES   (3),
        .DEBOUNCE_CYCLES(4),
        .INITIAL_STATE  (4'b0001)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .VS        (VS),
        .BtnNext   (BtnNext),
        .BtnMode   (BtnMode),
        .ImageState(ImageState),
        .AutoMode  (AutoMode),
        .FrameTick (FrameTick)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // One VS pulse held high for 'high' cycles, then a low gap.
    task automatic vs_pulse(input int high);
        @(negedge Clock);
        VS = 1'b1;
        repeat (high) @(negedge Clock);
        VS = 1'b0;
        repeat (4) @(negedge Clock);
    endtask

    task automatic press_btn(input bit is_mode, input int low, input int high);
        @(negedge Clock);
        if (is_mode) BtnMode = 1'b0; else BtnNext = 1'b0;
        repeat (low) @(negedge Clock);
        if (is_mode) BtnMode = 1'b1; else BtnNext = 1'b1;
        repeat (high) @(negedge Clock);
    endtask

    task automatic expect_tick(input logic [3:0] st, input logic am);
        exp_t e;
        e.state     = st;
        e.auto_mode = am;
        exp_q.push_back(e);
    endtask

    // Scoreboard: on a tick the pattern must still be the old one; one cycle
    // later it must equal the next queued expectation.
    always @(negedge Clock) begin
        if (!Reset) begin
            cmp_due = 1'b0;
        end else begin
            if (cmp_due) begin
                cmp_due = 1'b0;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_tick actual=%0h required=none", ImageState);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("state_after_tick", 32'(ImageState), 32'(e.state));
                    check("auto_after_tick", 32'(AutoMode), 32'(e.auto_mode));
                    prev_state = e.state;
                end
            end
            if (FrameTick) begin
                check("state_on_tick", 32'(ImageState), 32'(prev_state));
                cmp_due = 1'b1;
            end
        end
    end

    task automatic check_drained(input string name);
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[7];
        checks     = 0;
        failures   = 0;
        cmp_due    = 1'b0;
        prev_state = 4'b0001;
        Reset      = 1'b0;
        VS         = 1'b0;
        BtnNext    = 1'b1;
        BtnMode    = 1'b1;

        // Auto cycling from reset: three ticks per pattern, VS widths varied.
        vecs[0] = '{1, 4'b0001, 1'b1};
        vecs[1] = '{3, 4'b0001, 1'b1};
        vecs[2] = '{2, 4'b0010, 1'b1};
        vecs[3] = '{4, 4'b0010, 1'b1};
        vecs[4] = '{1, 4'b0010, 1'b1};
        vecs[5] = '{3, 4'b0100, 1'b1};
        vecs[6] = '{2, 4'b0100, 1'b1};

        repeat (3) @(negedge Clock);
        check("reset_state", 32'(ImageState), 32'h1);
        check("reset_auto", 32'(AutoMode), 32'h1);
        check("reset_tick", 32'(FrameTick), 32'h0);
        Reset = 1'b1;
        repeat (2) @(negedge Clock);

        for (int i = 0; i < 7; i++) begin
            expect_tick(vecs[i].exp_state, vecs[i].exp_auto);
            vs_pulse(vecs[i].vs_high);
        end
        check_drained("auto_cycle_ticks");

        // Mode press: manual after the debounce, release must not toggle back.
        @(negedge Clock);
        BtnMode = 1'b0;
        repeat (10) @(negedge Clock);
        check("mode_press_manual", 32'(AutoMode), 32'h0);
        BtnMode = 1'b1;
        repeat (12) @(negedge Clock);
        check("mode_release_manual", 32'(AutoMode), 32'h0);
        for (int i = 0; i < 5; i++) begin
            expect_tick(4'b0100, 1'b0);
            vs_pulse(2);
        end
        check_drained("manual_hold_ticks");

        // Three next presses within one frame: one advance only.
        for (int i = 0; i < 3; i++) press_btn(1'b0, 10, 10);
        expect_tick(4'b1000, 1'b0);
        vs_pulse(2);
        expect_tick(4'b1000, 1'b0);
        vs_pulse(2);
        check_drained("multi_press_ticks");

        // Bounces shorter than the debounce window: no press, no advance.
        for (int i = 0; i < 5; i++) press_btn(1'b0, 3, 3);
        expect_tick(4'b1000, 1'b0);
        vs_pulse(2);
        check_drained("bounce_ticks");

        // Back to auto, then a pending press on the dwell-expiry frame.
        press_btn(1'b1, 10, 12);
        check("mode_press_auto", 32'(AutoMode), 32'h1);
        expect_tick(4'b1000, 1'b1);
        vs_pulse(2);
        expect_tick(4'b1000, 1'b1);
        vs_pulse(2);
        press_btn(1'b0, 10, 12);
        expect_tick(4'b0001, 1'b1);
        vs_pulse(2);
        expect_tick(4'b0001, 1'b1);
        vs_pulse(2);
        expect_tick(4'b0001, 1'b1);
        vs_pulse(2);
        expect_tick(4'b0010, 1'b1);
        vs_pulse(2);
        check_drained("pending_expiry_ticks");

        // Step to GRAY_SCALE, leave a press pending plus a partial mode debounce,
        // then reset: everything pending must be discarded.
        press_btn(1'b0, 10, 12);
        expect_tick(4'b0100, 1'b1);
        vs_pulse(2);
        press_btn(1'b0, 10, 12);
        expect_tick(4'b1000, 1'b1);
        vs_pulse(2);
        check_drained("step_to_gray_ticks");
        press_btn(1'b0, 10, 12);
        @(negedge Clock);
        BtnMode = 1'b0;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        BtnMode = 1'b1;
        repeat (3) @(negedge Clock);
        check("midreset_state", 32'(ImageState), 32'h1);
        check("midreset_auto", 32'(AutoMode), 32'h1);
        Reset = 1'b1;
        prev_state = 4'b0001;
        repeat (8) @(negedge Clock);
        check("post_reset_auto", 32'(AutoMode), 32'h1);
        expect_tick(4'b0001, 1'b1);
        vs_pulse(2);
        expect_tick(4'b0001, 1'b1);
        vs_pulse(2);
        expect_tick(4'b0010, 1'b1);
        vs_pulse(2);
        check_drained("post_reset_ticks");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
